lcd_reader: RTL and testbench

Nios II multi-cycle custom instruction that reads from the HD44780-compatible 16x2 LCD. It reads either the status register (busy flag and address counter) or the DDRAM/CGRAM data register. An optional poll mode repeats status reads until the busy flag clears or a timeout expires. It shares the LCD pins with the existing write-side driver. The top level uses `active` to select which block drives rs/rw/en and to tristate `db` toward the LCD while a read is in progress.

---
 rtl/lcd_reader_if.sv | 18 +
 rtl/lcd_reader.sv | 179 +++++++++++++++++
 tb/tb_lcd_reader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_reader_if.sv
// lcd_reader_if: Nios II multi-cycle custom-instruction bus for lcd_reader.
//   clk_en        - custom-instruction clock enable (CPU -> block)
//   start         - instruction start strobe        (CPU -> block)
//   dataa, datab  - instruction operands            (CPU -> block)
//   result        - instruction result              (block -> CPU)
//   done          - one-cycle completion pulse      (block -> CPU)
// master = CPU side, slave = lcd_reader.
interface lcd_reader_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  modport master (output clk_en, start, dataa, datab, input result, done);
  modport slave  (input clk_en, start, dataa, datab, output result, done);
endinterface

// File: rtl/lcd_reader.sv
// lcd_reader: reads the HD44780 status register (busy flag + address counter)
// or the DDRAM/CGRAM data register, with an optional poll mode that repeats
// status reads until the busy flag clears or MAX_POLLS reads have been made.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-low reset
//   ci       - custom-instruction bus (slave modport)
//   rs,rw,en - LCD control pins (valid while active=1)
//   db_in    - LCD data bus as seen through the top-level tristate
//   active   - high for the whole transaction; top level hands the pins here
// result = {timeout, reads[14:0], 8'h00, byte}.
module lcd_reader #(
  parameter int T_SETUP   = 5,
  parameter int T_EN_HIGH = 25,
  parameter int T_EN_LOW  = 50,
  parameter int MAX_POLLS = 1000
) (
  input  logic         clk,
  input  logic         reset,
  lcd_reader_if.slave  ci,
  output logic         rs,
  output logic         rw,
  output logic         en,
  input  logic [7:0]   db_in,
  output logic         active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    EN_HIGH = 3'd2,
    EN_LOW  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [15:0] SETUP_LAST = 16'(T_SETUP - 1);
  localparam logic [15:0] HIGH_LAST  = 16'(T_EN_HIGH - 1);
  localparam logic [15:0] LOW_LAST   = 16'(T_EN_LOW - 1);
  localparam logic [15:0] MAX_READS  = 16'(MAX_POLLS);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] reads_q, reads_d;
  logic [7:0]  data_q, data_d;
  logic        poll_q, poll_d;
  logic        rs_q, rs_d;
  logic        rw_q, rw_d;
  logic        en_q, en_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  // Upper operand bits and datab carry no meaning for this instruction.
  logic unused_s;
  assign unused_s = ^{ci.dataa[31:2], ci.datab};

  // Next-state and next-output logic; everything holds while clk_en is low.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reads_d  = reads_q;
    data_d   = data_q;
    poll_d   = poll_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    en_d     = en_q;
    active_d = active_q;
    done_d   = done_q;
    result_d = result_q;
    if (ci.clk_en) begin
      case (state_q)
        IDLE: begin
          done_d = 1'b0;
          if (ci.start) begin
            rs_d     = ci.dataa[0];
            // Polling only makes sense on the status register.
            poll_d   = ci.dataa[1] & ~ci.dataa[0];
            rw_d     = 1'b1;
            active_d = 1'b1;
            reads_d  = 16'd0;
            cnt_d    = 16'd0;
            state_d  = SETUP;
          end else begin
            cnt_d = 16'd0;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            en_d    = 1'b1;
            cnt_d   = 16'd0;
            state_d = EN_HIGH;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        EN_HIGH: begin
          if (cnt_q == HIGH_LAST) begin
            // Sample on the same edge that drops en.
            data_d  = db_in;
            en_d    = 1'b0;
            reads_d = reads_q + 16'd1;
            cnt_d   = 16'd0;
            state_d = EN_LOW;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        EN_LOW: begin
          if (cnt_q == LOW_LAST) begin
            cnt_d = 16'd0;
            // reads already counts the access that just finished.
            if (poll_q && data_q[7] && (reads_q < MAX_READS)) begin
              state_d = SETUP;
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        DONE: begin
          done_d   = 1'b1;
          result_d = {poll_q & data_q[7], reads_q[14:0], 8'h00, data_q};
          rw_d     = 1'b0;
          active_d = 1'b0;
          cnt_d    = 16'd0;
          state_d  = IDLE;
        end
        default: begin
          en_d     = 1'b0;
          rw_d     = 1'b0;
          active_d = 1'b0;
          done_d   = 1'b0;
          cnt_d    = 16'd0;
          state_d  = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      reads_q  <= 16'd0;
      data_q   <= 8'h00;
      poll_q   <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      en_q     <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reads_q  <= reads_d;
      data_q   <= data_d;
      poll_q   <= poll_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      en_q     <= en_d;
      active_q <= active_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign rs        = rs_q;
  assign rw        = rw_q;
  assign en        = en_q;
  assign active    = active_q;
  assign ci.done   = done_q;
  assign ci.result = result_q;

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: self-checking bench for lcd_reader. Two instances share the
// clock: dut0 with default parameters, dut1 with MAX_POLLS=4 for timeouts.
module tb_lcd_reader;
  localparam int TS = 5;
  localparam int TH = 25;
  localparam int TL = 50;
  localparam int TP = TS + TH + TL;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        sel;
  logic [7:0]  db_in = 8'h00;

  always #10 clk = ~clk;

  lcd_reader_if ci0 ();
  lcd_reader_if ci1 ();
  logic rs0, rw0, en0, act0, rs1, rw1, en1, act1;

  assign ci0.clk_en = clk_en;
  assign ci0.start  = start & ~sel;
  assign ci0.dataa  = dataa;
  assign ci0.datab  = 32'h0000_0000;
  assign ci1.clk_en = clk_en;
  assign ci1.start  = start & sel;
  assign ci1.dataa  = dataa;
  assign ci1.datab  = 32'h0000_0000;

  lcd_reader #(.T_SETUP(TS), .T_EN_HIGH(TH), .T_EN_LOW(TL), .MAX_POLLS(1000)) dut0 (
    .clk(clk), .reset(reset), .ci(ci0), .rs(rs0), .rw(rw0), .en(en0),
    .db_in(db_in), .active(act0));
  lcd_reader #(.T_SETUP(TS), .T_EN_HIGH(TH), .T_EN_LOW(TL), .MAX_POLLS(4)) dut1 (
    .clk(clk), .reset(reset), .ci(ci1), .rs(rs1), .rw(rw1), .en(en1),
    .db_in(db_in), .active(act1));

  logic        rs_m, rw_m, en_m, act_m, done_m;
  logic [31:0] res_m;
  assign rs_m   = sel ? rs1 : rs0;
  assign rw_m   = sel ? rw1 : rw0;
  assign en_m   = sel ? en1 : en0;
  assign act_m  = sel ? act1 : act0;
  assign done_m = sel ? ci1.done : ci0.done;
  assign res_m  = sel ? ci1.result : ci0.result;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bytes the LCD returns, one per en pulse (last entry repeats).
  logic [7:0] db_seq [0:7];
  int txn_id = 0;

  // Bus monitor: drives db_in per pulse and collects pulse statistics.
  int   m_id = -1, m_pulses = 0, m_cur = 0, m_minw = 0, m_maxw = 0, m_viol = 0;
  logic en_prev = 1'b0, act_prev = 1'b0, rs_prev = 1'b0;
  always @(negedge clk) begin
    if (m_id != txn_id) begin
      m_id = txn_id; m_pulses = 0; m_minw = 99999; m_maxw = 0; m_viol = 0;
    end
    if (en_m && !en_prev) begin
      db_in = db_seq[(m_pulses > 7) ? 7 : m_pulses];
      m_pulses++;
      m_cur = 0;
    end
    if (en_m) m_cur++;
    if (!en_m && en_prev) begin
      if (m_cur < m_minw) m_minw = m_cur;
      if (m_cur > m_maxw) m_maxw = m_cur;
    end
    if (en_m && !rw_m) m_viol++;
    if (act_m && act_prev && (rs_m !== rs_prev)) m_viol++;
    en_prev = en_m; act_prev = act_m; rs_prev = rs_m;
  end

  // One full transaction with bounded wait for done, then all checks.
  task automatic run_txn(input logic s, input logic [31:0] a, input int gate_at,
                         input logic [31:0] exp_res, input int exp_cyc,
                         input int exp_pulses, input int exp_w, input string tag);
    int cyc;
    bit got;
    sel = s;
    txn_id++;
    @(negedge clk);
    start = 1'b1; dataa = a;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; cyc = 0; got = 1'b0;
    check({tag, ".launch"}, {29'd0, act_m, rw_m, rs_m}, {29'd0, 1'b1, 1'b1, a[0]});
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (gate_at > 0 && cyc == gate_at) clk_en = 1'b0;
      if (gate_at > 0 && cyc == gate_at + 10) clk_en = 1'b1;
      if (done_m) got = 1'b1;
    end
    clk_en = 1'b1;
    check({tag, ".done_cycle"}, cyc, exp_cyc);
    check({tag, ".result"}, res_m, exp_res);
    check({tag, ".pulses"}, m_pulses, exp_pulses);
    check({tag, ".en_width"}, {m_minw[15:0], m_maxw[15:0]}, {exp_w[15:0], exp_w[15:0]});
    check({tag, ".bus_rules"}, m_viol, 0);
    check({tag, ".release"}, {30'd0, act_m, rw_m}, 32'd0);
    @(negedge clk);
    check({tag, ".done_pulse"}, {31'd0, done_m}, 32'd0);
    check({tag, ".result_hold"}, res_m, exp_res);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] dbs;
    int          gate_at;
    logic [31:0] exp_res;
    int          exp_cyc;
    int          exp_pulses;
    int          exp_w;
  } vec_t;

  vec_t vec [0:9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dones;
    bit got;
    reset = 1'b0; clk_en = 1'b1; start = 1'b0; dataa = 32'd0; sel = 1'b0;
    for (int j = 0; j < 8; j++) db_seq[j] = 8'h00;

    vec[0] = '{1'b0, 32'h0000_0000, 32'h2525_2525, 0,  32'h0001_0025, 81,  1, 25};
    vec[1] = '{1'b0, 32'h0000_0001, 32'h4141_4141, 0,  32'h0001_0041, 81,  1, 25};
    vec[2] = '{1'b0, 32'h0000_0003, 32'h4141_4141, 0,  32'h0001_0041, 81,  1, 25};
    vec[3] = '{1'b0, 32'h0000_0002, 32'h0780_8080, 0,  32'h0004_0007, 321, 4, 25};
    vec[4] = '{1'b1, 32'h0000_0002, 32'h8080_8080, 0,  32'h8004_0080, 321, 4, 25};
    vec[5] = '{1'b0, 32'h0000_0000, 32'h2525_2525, 10, 32'h0001_0025, 91,  1, 35};
    vec[6] = '{1'b0, 32'h0000_0002, 32'h1212_1212, 0,  32'h0001_0012, 81,  1, 25};
    vec[7] = '{1'b0, 32'h0000_0000, 32'hA5A5_A5A5, 0,  32'h0001_00A5, 81,  1, 25};
    vec[8] = '{1'b0, 32'hFFFF_FFF0, 32'h8080_8080, 0,  32'h0001_0080, 81,  1, 25};
    vec[9] = '{1'b1, 32'h0000_0001, 32'h8080_8080, 0,  32'h0001_0080, 81,  1, 25};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset.dut0", {ci0.result, 26'd0, ci0.done, rs0, rw0, en0, act0, 1'b0},
          {32'd0, 32'd0});
    check("reset.dut1", {26'd0, ci1.done, rs1, rw1, en1, act1, 1'b0} | ci1.result, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 8; j++) db_seq[j] = vec[i].dbs[8 * ((j > 3) ? 3 : j) +: 8];
      run_txn(vec[i].s, vec[i].a, vec[i].gate_at, vec[i].exp_res, vec[i].exp_cyc,
              vec[i].exp_pulses, vec[i].exp_w, $sformatf("vec%0d", i));
    end

    // Reset in the middle of EN_HIGH.
    sel = 1'b0;
    txn_id++;
    for (int j = 0; j < 8; j++) db_seq[j] = 8'h55;
    @(negedge clk);
    start = 1'b1; dataa = 32'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("midreset.en_high", {31'd0, en_m}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midreset.outputs", {28'd0, en_m, rw_m, act_m, done_m}, 32'd0);
    check("midreset.result", res_m, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (200) begin
      @(negedge clk);
      if (done_m || act_m) dones++;
    end
    check("midreset.no_done", dones, 0);
    run_txn(1'b0, 32'h0000_0000, 0, 32'h0001_0055, 81, 1, 25, "after_reset");

    // start held high: ignored while busy, re-triggers right after DONE.
    sel = 1'b0;
    txn_id++;
    for (int j = 0; j < 8; j++) db_seq[j] = 8'h41;
    @(negedge clk);
    start = 1'b1; dataa = 32'd1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done_m) got = 1'b1;
    end
    check("held.first", {cyc[15:0], res_m[15:0]}, {16'd82, 16'h0041});
    @(negedge clk);
    check("held.retrigger", {30'd0, act_m, done_m}, {30'd0, 1'b1, 1'b0});
    start = 1'b0;
    cyc = 1; got = 1'b0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done_m) got = 1'b1;
    end
    check("held.second_cycle", cyc, 82);
    check("held.second_result", res_m, 32'h0001_0041);
    @(negedge clk);

    // Randomized transactions against a read-sequence model.
    for (int i = 0; i < 12; i++) begin
      logic        s;
      logic [31:0] a;
      logic        pl;
      logic [7:0]  b;
      int          maxp;
      int          n;
      s = 1'(($urandom_range(0, 1)));
      a = $urandom;
      for (int j = 0; j < 8; j++) begin
        b = 8'($urandom_range(0, 255));
        b[7] = ($urandom_range(0, 2) != 0);
        db_seq[j] = b;
      end
      db_seq[7][7] = 1'b0;
      pl = a[1] & ~a[0];
      maxp = s ? 4 : 1000;
      n = 0;
      b = 8'h00;
      do begin
        b = db_seq[(n > 7) ? 7 : n];
        n++;
      end while (pl && b[7] && n < maxp);
      run_txn(s, a, 0, {pl & b[7], 15'(n), 8'h00, b}, 1 + n * TP, n, TH,
              $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
